// File: rtl/pipe_pkg.sv
// Shared definitions for the EX stage: ALU/MDU opcodes, MDU sizing, FSM encoding.
package pipe_pkg;

    localparam int XLEN     = 32;
    localparam int MDU_ITER = 32;   // one quotient/product bit per cycle

    localparam logic [4:0] ALUC_ADD   = 5'b00000;
    localparam logic [4:0] ALUC_SUB   = 5'b00001;
    localparam logic [4:0] ALUC_AND   = 5'b00010;
    localparam logic [4:0] ALUC_OR    = 5'b00011;
    localparam logic [4:0] ALUC_XOR   = 5'b00100;
    localparam logic [4:0] ALUC_LUI   = 5'b00101;
    localparam logic [4:0] ALUC_SLL   = 5'b00110;
    localparam logic [4:0] ALUC_SRL   = 5'b00111;
    localparam logic [4:0] ALUC_SRA   = 5'b01000;
    localparam logic [4:0] ALUC_SLT   = 5'b01001;
    localparam logic [4:0] ALUC_SLTU  = 5'b01010;
    localparam logic [4:0] ALUC_MULT  = 5'b10000;
    localparam logic [4:0] ALUC_MULTU = 5'b10001;
    localparam logic [4:0] ALUC_DIV   = 5'b10010;
    localparam logic [4:0] ALUC_DIVU  = 5'b10011;
    localparam logic [4:0] ALUC_MFHI  = 5'b10100;
    localparam logic [4:0] ALUC_MFLO  = 5'b10101;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    // MULT/MULTU/DIV/DIVU share the 100xx prefix; low two bits select the op
    function automatic logic is_mdu_op(input logic [4:0] aluc);
        return aluc[4:2] == 3'b100;
    endfunction

endpackage

// File: rtl/pipe_mdu_seq.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide on
// magnitudes, sign fix-up on the final step, HI/LO result registers.
module pipe_mdu_seq
    import pipe_pkg::*;
(
    input  logic            clk,
    input  logic            clrn,
    input  logic            start,
    input  logic [1:0]      op,      // 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CNT_W = $clog2(MDU_ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_ITER - 1);

    mdu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] acc_hi_q, acc_hi_d;  // partial product high / remainder
    logic [XLEN-1:0] acc_lo_q, acc_lo_d;  // multiplier / dividend -> quotient
    logic [XLEN-1:0] m_q, m_d;            // multiplicand / divisor magnitude
    logic [XLEN-1:0] dvd_q, dvd_d;        // raw dividend, returned on divide by zero
    logic            is_div_q, is_div_d;
    logic            neg_q, neg_d;        // product / quotient is negative
    logic            rneg_q, rneg_d;      // remainder is negative
    logic            dz_q, dz_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;

    logic            sgn, sa, sb;
    logic [XLEN-1:0] amag, bmag, mul_add, step_hi, step_lo;
    logic [XLEN:0]   mul_sum, div_sh, div_diff;
    logic            div_ge;
    logic [2*XLEN-1:0] prod;

    // Operand magnitudes and sign info for a new operation
    always_comb begin
        sgn  = ~op[0];
        sa   = sgn & a[XLEN-1];
        sb   = sgn & b[XLEN-1];
        amag = sa ? -a : a;
        bmag = sb ? -b : b;
    end

    // One iteration of either algorithm, from the current accumulators
    always_comb begin
        mul_add  = acc_lo_q[0] ? m_q : '0;
        mul_sum  = {1'b0, acc_hi_q} + {1'b0, mul_add};
        div_sh   = {acc_hi_q, acc_lo_q[XLEN-1]};
        div_diff = div_sh - {1'b0, m_q};
        div_ge   = div_sh >= {1'b0, m_q};
        if (is_div_q) begin
            step_hi = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
            step_lo = {acc_lo_q[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo_q[XLEN-1:1]};
        end
        prod = {step_hi, step_lo};
    end

    // FSM next state, iteration registers and HI/LO write-back
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        m_d      = m_q;
        dvd_d    = dvd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                busy = start;
                if (start) begin
                    acc_hi_d = '0;
                    acc_lo_d = amag;
                    m_d      = bmag;
                    dvd_d    = a;
                    is_div_d = op[1];
                    neg_d    = sa ^ sb;
                    rneg_d   = sa;
                    dz_d     = op[1] & (b == '0);
                    cnt_d    = '0;
                    state_d  = MDU_BUSY;
                end
            end
            MDU_BUSY: begin
                busy     = 1'b1;
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    if (is_div_q) begin
                        lo_d = dz_q ? '1    : (neg_q  ? -step_lo : step_lo);
                        hi_d = dz_q ? dvd_q : (rneg_q ? -step_hi : step_hi);
                    end else begin
                        {hi_d, lo_d} = neg_q ? -prod : prod;
                    end
                    state_d = MDU_DONE;
                end
            end
            MDU_DONE: begin
                // op is still in EX this cycle; it leaves now, so never restart here
                done    = 1'b1;
                state_d = MDU_IDLE;
            end
            default: state_d = MDU_IDLE;
        endcase
        // stall drops the instant reset is asserted
        busy = busy & clrn;
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= MDU_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            m_q      <= '0;
            dvd_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            m_q      <= m_d;
            dvd_q    <= dvd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/pipe_exe_stage.sv
// EX stage: operand selection, single-cycle ALU, MDU hookup, EX/MEM register.
module pipe_exe_stage
    import pipe_pkg::*;
(
    input  logic            clk,
    input  logic            clrn,
    input  logic            ewreg,
    input  logic            em2reg,
    input  logic            ewmem,
    input  logic [4:0]      ealuc,
    input  logic            ealuimm,
    input  logic            eshift,
    input  logic            ejal,
    input  logic [XLEN-1:0] ea,
    input  logic [XLEN-1:0] eb,
    input  logic [XLEN-1:0] eimm,
    input  logic [4:0]      ern,
    input  logic [XLEN-1:0] epc4,
    output logic            estall,
    output logic            mwreg,
    output logic            mm2reg,
    output logic            mwmem,
    output logic [XLEN-1:0] malu,
    output logic [XLEN-1:0] mb,
    output logic [4:0]      mrn
);

    logic [XLEN-1:0] opa, opb, alu_res, mdu_hi, mdu_lo;
    logic [4:0]      shamt;
    logic            mdu_done;

    logic            mwreg_q, mwreg_d, mm2reg_q, mm2reg_d, mwmem_q, mwmem_d;
    logic [XLEN-1:0] malu_q, malu_d, mb_q, mb_d;
    logic [4:0]      mrn_q, mrn_d;

    pipe_mdu_seq u_mdu (
        .clk   (clk),
        .clrn  (clrn),
        .start (is_mdu_op(ealuc)),
        .op    (ealuc[1:0]),
        .a     (ea),
        .b     (eb),
        .busy  (estall),
        .done  (mdu_done),
        .hi    (mdu_hi),
        .lo    (mdu_lo)
    );

    // Operand muxes and single-cycle ALU
    always_comb begin
        opa   = eshift  ? {{(XLEN-5){1'b0}}, eimm[10:6]} : ea;
        opb   = ealuimm ? eimm : eb;
        shamt = opa[4:0];
        alu_res = '0;
        case (ealuc)
            ALUC_ADD:  alu_res = opa + opb;
            ALUC_SUB:  alu_res = opa - opb;
            ALUC_AND:  alu_res = opa & opb;
            ALUC_OR:   alu_res = opa | opb;
            ALUC_XOR:  alu_res = opa ^ opb;
            ALUC_LUI:  alu_res = {opb[15:0], 16'b0};
            ALUC_SLL:  alu_res = opb << shamt;
            ALUC_SRL:  alu_res = opb >> shamt;
            ALUC_SRA:  alu_res = $signed(opb) >>> shamt;
            ALUC_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
            ALUC_SLTU: alu_res = {{(XLEN-1){1'b0}}, opa < opb};
            ALUC_MFHI: alu_res = mdu_hi;
            ALUC_MFLO: alu_res = mdu_lo;
            default:   alu_res = '0;
        endcase
    end

    // EX/MEM next values: bubble while stalled, MDU op never writes a GPR
    always_comb begin
        mwreg_d  = ewreg  & ~estall & ~mdu_done;
        mm2reg_d = em2reg & ~estall;
        mwmem_d  = ewmem  & ~estall;
        malu_d   = ejal ? epc4 + XLEN'(4) : alu_res;
        mb_d     = eb;
        mrn_d    = ejal ? 5'd31 : ern;
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mwreg_q  <= 1'b0;
            mm2reg_q <= 1'b0;
            mwmem_q  <= 1'b0;
            malu_q   <= '0;
            mb_q     <= '0;
            mrn_q    <= '0;
        end else begin
            mwreg_q  <= mwreg_d;
            mm2reg_q <= mm2reg_d;
            mwmem_q  <= mwmem_d;
            malu_q   <= malu_d;
            mb_q     <= mb_d;
            mrn_q    <= mrn_d;
        end
    end

    assign mwreg  = mwreg_q;
    assign mm2reg = mm2reg_q;
    assign mwmem  = mwmem_q;
    assign malu   = malu_q;
    assign mb     = mb_q;
    assign mrn    = mrn_q;

endmodule

// File: tb/tb_pipe_exe_stage.sv
// Self-checking bench for pipe_exe_stage: ALU ops, jal, MDU stall/bubbles,
// HI/LO read-back, reset abort and back-to-back MDU ops.
module tb_pipe_exe_stage;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        clrn;
    logic        ewreg, em2reg, ewmem, ealuimm, eshift, ejal;
    logic [4:0]  ealuc, ern;
    logic [31:0] ea, eb, eimm, epc4;
    logic        estall, mwreg, mm2reg, mwmem;
    logic [31:0] malu, mb;
    logic [4:0]  mrn;

    typedef struct {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [31:0] alu;
        logic [4:0]  rn;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    pipe_exe_stage dut (
        .clk(clk), .clrn(clrn), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .ealuc(ealuc), .ealuimm(ealuimm), .eshift(eshift), .ejal(ejal),
        .ea(ea), .eb(eb), .eimm(eimm), .ern(ern), .epc4(epc4),
        .estall(estall), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .malu(malu), .mb(mb), .mrn(mrn)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Independent reference for MDU results: {HI, LO}
    function automatic logic [63:0] mdu_ref(input logic [4:0] aluc, input logic [31:0] a, b);
        longint sa, sb2;
        int     ia, ib;
        case (aluc)
            ALUC_MULT: begin
                sa = longint'($signed(a)); sb2 = longint'($signed(b));
                return 64'(sa * sb2);
            end
            ALUC_MULTU: return {32'b0, a} * {32'b0, b};
            ALUC_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                ia = a; ib = b;
                return {32'(ia % ib), 32'(ia / ib)};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic set_op(input logic [4:0] aluc, input logic [31:0] a, b, imm,
                          input logic [4:0] rn, input logic wreg, m2reg, wmem,
                          aluimm, shift, jal, input logic [31:0] pc4);
        ealuc = aluc; ea = a; eb = b; eimm = imm; ern = rn;
        ewreg = wreg; em2reg = m2reg; ewmem = wmem;
        ealuimm = aluimm; eshift = shift; ejal = jal; epc4 = pc4;
    endtask

    // Called right after a capturing edge: pop the oldest expectation and compare
    task automatic pop_check(input string nm);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", nm);
            return;
        end
        e = sb.pop_front();
        if ({mwreg, mm2reg, mwmem} !== {e.wreg, e.m2reg, e.wmem}) begin
            errors++;
            $display("FAIL %s ctl: got %b%b%b want %b%b%b", nm, mwreg, mm2reg, mwmem,
                     e.wreg, e.m2reg, e.wmem);
        end else if (e.chk_data && (malu !== e.alu || mrn !== e.rn)) begin
            errors++;
            $display("FAIL %s data: got malu=%h mrn=%0d want malu=%h mrn=%0d",
                     nm, malu, mrn, e.alu, e.rn);
        end
    endtask

    task automatic alu_op(input string nm, input logic [4:0] aluc, input logic [31:0] a, b, imm,
                          input logic [4:0] rn, input logic wreg, m2reg, wmem, aluimm, shift, jal,
                          input logic [31:0] pc4, input logic [31:0] exp_alu, input logic [4:0] exp_rn);
        exp_t e;
        set_op(aluc, a, b, imm, rn, wreg, m2reg, wmem, aluimm, shift, jal, pc4);
        e.wreg = wreg; e.m2reg = m2reg; e.wmem = wmem;
        e.alu = exp_alu; e.rn = exp_rn; e.chk_data = 1'b1;
        sb.push_back(e);
        #4;
        checks++;
        if (estall !== 1'b0) begin
            errors++;
            $display("FAIL %s estall: got %b want 0", nm, estall);
        end
        @(posedge clk); #1;
        pop_check(nm);
    endtask

    task automatic rr(input string nm, input logic [4:0] aluc, input logic [31:0] a, b,
                      input logic [31:0] exp_alu);
        alu_op(nm, aluc, a, b, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, exp_alu, 5'd3);
    endtask

    // Issue an MDU op, count stall cycles, check bubbles and the DONE pass-through
    task automatic mdu_run(input string nm, input logic [4:0] aluc, input logic [31:0] a, b);
        exp_t e;
        int   n = 0;
        set_op(aluc, a, b, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        forever begin
            #4;
            if (estall !== 1'b1) break;
            n++;
            @(posedge clk); #1;
            checks++;
            if ({mwreg, mm2reg, mwmem} !== 3'b000) begin
                errors++;
                $display("FAIL %s bubble%0d: got %b%b%b want 000", nm, n, mwreg, mm2reg, mwmem);
            end
            if (n > 40) break;
        end
        checks++;
        if (n != 33) begin
            errors++;
            $display("FAIL %s stall_len: got %0d want 33", nm, n);
        end
        e.wreg = 1'b0; e.m2reg = 1'b0; e.wmem = 1'b0; e.alu = '0; e.rn = '0; e.chk_data = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1;
        pop_check({nm, "_done"});
    endtask

    task automatic mdu_check(input string nm, input logic [4:0] aluc, input logic [31:0] a, b);
        logic [63:0] r;
        r = mdu_ref(aluc, a, b);
        mdu_run(nm, aluc, a, b);
        rr({nm, "_hi"}, ALUC_MFHI, 32'h0, 32'h0, r[63:32]);
        rr({nm, "_lo"}, ALUC_MFLO, 32'h0, 32'h0, r[31:0]);
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        set_op(ALUC_ADD, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        checks++;
        if ({estall, mwreg, mm2reg, mwmem, malu, mb, mrn} !== '0) begin
            errors++;
            $display("FAIL reset: got estall=%b ctl=%b%b%b malu=%h mb=%h mrn=%0d want all 0",
                     estall, mwreg, mm2reg, mwmem, malu, mb, mrn);
        end
        clrn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        alu_op("addi", ALUC_ADD, 32'd5, 32'h0, 32'hFFFF_FFFD, 5'd8, 1, 0, 0, 1, 0, 0, 32'h0, 32'd2, 5'd8);
        rr("sub",  ALUC_SUB,  32'd5, 32'd7, 32'hFFFF_FFFE);
        rr("and",  ALUC_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
        rr("or",   ALUC_OR,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
        rr("xor",  ALUC_XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
        alu_op("lui", ALUC_LUI, 32'h0, 32'h0, 32'h0000_1234, 5'd4, 1, 0, 0, 1, 0, 0, 32'h0, 32'h1234_0000, 5'd4);
        alu_op("sll", ALUC_SLL, 32'h0, 32'h1, 32'h0000_0100, 5'd5, 1, 0, 0, 0, 1, 0, 32'h0, 32'h10, 5'd5);
        alu_op("srl", ALUC_SRL, 32'h0, 32'h8000_0000, 32'h0000_0100, 5'd5, 1, 0, 0, 0, 1, 0, 32'h0, 32'h0800_0000, 5'd5);
        alu_op("sra", ALUC_SRA, 32'h0, 32'h8000_0000, 32'h0000_0100, 5'd5, 1, 0, 0, 0, 1, 0, 32'h0, 32'hF800_0000, 5'd5);
        rr("sllv31", ALUC_SLL, 32'd31, 32'h1, 32'h8000_0000);
        rr("slt",  ALUC_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1);
        rr("sltu", ALUC_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
        rr("undef", 5'b11111, 32'd5, 32'd7, 32'd0);
        alu_op("jal", ALUC_ADD, 32'd1, 32'd2, 32'h0, 5'd0, 1, 0, 0, 0, 0, 1, 32'h100, 32'h104, 5'd31);
        alu_op("load", ALUC_ADD, 32'h1000, 32'h0, 32'h8, 5'd6, 1, 1, 0, 1, 0, 0, 32'h0, 32'h1008, 5'd6);
        alu_op("store", ALUC_ADD, 32'h2000, 32'hABCD, 32'h4, 5'd0, 0, 0, 1, 1, 0, 0, 32'h0, 32'h2004, 5'd0);
        checks++;
        if (mb !== 32'hABCD) begin
            errors++;
            $display("FAIL store_data: got mb=%h want abcd", mb);
        end
    endtask

    task automatic test_mdu();
        mdu_check("multu", ALUC_MULTU, 32'hFFFF_FFFF, 32'd2);
        mdu_check("div",   ALUC_DIV,   32'hFFFF_FFF9, 32'd2);
        mdu_check("divu0", ALUC_DIVU,  32'd9, 32'd0);
        mdu_check("div0s", ALUC_DIV,   32'hFFFF_FFF9, 32'd0);
    endtask

    task automatic test_reset_mid_mdu();
        set_op(ALUC_DIV, 32'd100, 32'd7, 32'h0, 5'd0, 1, 0, 0, 0, 0, 0, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        clrn = 1'b0;
        #1;
        checks++;
        if ({estall, mwreg, mm2reg, mwmem, malu, mb, mrn} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got estall=%b ctl=%b%b%b malu=%h mb=%h mrn=%0d want all 0",
                     estall, mwreg, mm2reg, mwmem, malu, mb, mrn);
        end
        sb.delete();
        set_op(ALUC_ADD, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 0, 32'h0);
        #2;
        clrn = 1'b1;
        @(posedge clk); #1;
        rr("rst_hi", ALUC_MFHI, 32'h0, 32'h0, 32'h0);
        rr("rst_lo", ALUC_MFLO, 32'h0, 32'h0, 32'h0);
        mdu_check("divu_after_rst", ALUC_DIVU, 32'd100, 32'd7);
    endtask

    task automatic test_back_to_back();
        logic [63:0] r;
        r = mdu_ref(ALUC_DIV, 32'd100, 32'hFFFF_FFF9);
        mdu_run("b2b_mult", ALUC_MULT, 32'hFFFF_FFFD, 32'd5);
        mdu_run("b2b_div",  ALUC_DIV,  32'd100, 32'hFFFF_FFF9);
        rr("b2b_lo", ALUC_MFLO, 32'h0, 32'h0, r[31:0]);
        rr("b2b_hi", ALUC_MFHI, 32'h0, 32'h0, r[63:32]);
        mdu_check("mult_neg", ALUC_MULT, 32'hFFFF_FFFD, 32'd5);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mdu();
        test_reset_mid_mdu();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
